// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg
//   Shared types for the round-robin arbiter.
//   rr_state_e : arbiter FSM state encoding (2-bit)
package rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
  } rr_state_e;

endpackage

// File: rtl/rr_arbiter_one_hot_encoder.sv
// rr_arbiter_one_hot_encoder
//   Maps a binary index to a one-hot vector, or all-zero when disabled.
//   data_i    : binary index
//   en_i      : when low the output is all-zero
//   one_hot_o : 2**DATA_WIDTH wide one-hot (or zero) vector
module rr_arbiter_one_hot_encoder #(
  parameter int DATA_WIDTH = 2
) (
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     en_i,
  output logic [2**DATA_WIDTH-1:0] one_hot_o
);

  always_comb begin
    one_hot_o = '0;
    if (en_i) begin
      one_hot_o[data_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter over N = 2**SEL_WIDTH requesters with an optional
//   hold-time limit (MAX_HOLD, 0 disables it).
//   i_clk         : clock, rising edge
//   i_reset       : synchronous active-high reset
//   i_req         : per-requester request levels
//   o_grant       : one-hot grant, zero when idle
//   o_grant_idx   : index of current holder (qualify with o_grant_valid)
//   o_grant_valid : a grant is active
//   o_preempt     : one-cycle pulse when the holder is rotated out by the limit
//
//   state    | meaning
//   ST_IDLE  | no grant outstanding, waiting for any request
//   ST_GRANT | cur_idx holds the resource
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int SEL_WIDTH = 2,
  parameter int MAX_HOLD  = 16,
  parameter int CNT_WIDTH = 8,
  localparam int N = 1 << SEL_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_grant,
  output logic [SEL_WIDTH-1:0] o_grant_idx,
  output logic                 o_grant_valid,
  output logic                 o_preempt
);

  // Value of hold_cnt on the holder's last permitted cycle.
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

  rr_state_e            state_q, state_d;
  logic [SEL_WIDTH-1:0] cur_idx_q, cur_idx_d;
  logic [SEL_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                 valid_q, valid_d;
  logic                 preempt_q, preempt_d;

  logic [N-1:0]         others;
  logic                 timeout;

  // First set bit of mask scanning upward from base+1 with wrap-around.
  // The index sum wraps naturally in SEL_WIDTH bits, which does the
  // rotate / find / un-rotate in one pass.
  function automatic logic [SEL_WIDTH-1:0] pick(input logic [N-1:0] mask,
                                                input logic [SEL_WIDTH-1:0] base);
    logic [SEL_WIDTH-1:0] idx;
    logic                 found;
    pick  = base;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = base + SEL_WIDTH'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign others  = i_req & ~(N'(1) << cur_idx_q);
  assign timeout = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    valid_d    = valid_q;
    preempt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          cur_idx_d  = pick(i_req, last_idx_q);
          hold_cnt_d = '0;
          valid_d    = 1'b1;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!i_req[cur_idx_q]) begin
          last_idx_d = cur_idx_q;
          hold_cnt_d = '0;
          if (|i_req) begin
            // Hand over on the same edge, no idle bubble.
            cur_idx_d = pick(i_req, cur_idx_q);
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (timeout && (|others)) begin
          cur_idx_d  = pick(others, cur_idx_q);
          hold_cnt_d = '0;
          preempt_d  = 1'b1;
        end else if (hold_cnt_q != {CNT_WIDTH{1'b1}}) begin
          // A lone holder past the limit keeps counting up to saturation.
          hold_cnt_d = hold_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cur_idx_q  <= '0;
      last_idx_q <= SEL_WIDTH'(N - 1);
      hold_cnt_q <= '0;
      valid_q    <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      last_idx_q <= last_idx_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q    <= valid_d;
      preempt_q  <= preempt_d;
    end
  end

  rr_arbiter_one_hot_encoder #(
    .DATA_WIDTH(SEL_WIDTH)
  ) u_one_hot_encoder (
    .data_i   (cur_idx_q),
    .en_i     (valid_q),
    .one_hot_o(o_grant)
  );

  assign o_grant_idx   = cur_idx_q;
  assign o_grant_valid = valid_q;
  assign o_preempt     = preempt_q;

endmodule
